// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter_pkg : shared encodings for the RAM port arbiter    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_port_arbiter_pkg;

    localparam int   DEF_BLOCK_WIDTH = 4;
    localparam logic RW_READ         = 1'b1;
    localparam logic RW_WRITE        = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_BLK = 3'd1,
        ST_WR_BLK = 3'd2,
        ST_IO_RD  = 3'd3,
        ST_IO_WR  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Values double as bit positions in the one-hot grant vector.
    typedef enum logic [1:0] {
        OWN_ICACHE = 2'd0,
        OWN_DCACHE = 2'd1,
        OWN_IO     = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_prio_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_prio_arb : io > dcache > icache select, starvation override|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_port_prio_arb
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       arb_en_i,
    input  logic       icache_req_i,
    input  logic       dcache_req_i,
    input  logic       io_req_i,
    output logic [2:0] grant_o
);
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    always_comb begin
        grant_o = 3'b000;
        if (arb_en_i) begin
            if (icache_req_i && (starve_q == LIMIT)) grant_o[OWN_ICACHE] = 1'b1;
            else if (io_req_i)                       grant_o[OWN_IO]     = 1'b1;
            else if (dcache_req_i)                   grant_o[OWN_DCACHE] = 1'b1;
            else if (icache_req_i)                   grant_o[OWN_ICACHE] = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!icache_req_i || grant_o[OWN_ICACHE])
            starve_d = '0;
        else if ((grant_o != 3'b000) && (starve_q != LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)     starve_q <= '0;
        else if (en_i) starve_q <= starve_d;
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter : shares the byte-wide RAM port between ICache,    |
// | DCache and uncached IO, sequencing transfers byte by byte. Rev 1.0  |
// +--------------------------------------------------------------------+
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clkIn,
    input  logic                          resetIn,
    input  logic                          readyIn,
    input  logic [7:0]                    memIn,
    output logic [31:0]                   memAddr,
    output logic [7:0]                    memOut,
    output logic                          readWriteOut,
    input  logic                          icacheReq,
    input  logic [31-BLOCK_WIDTH:0]       icacheAddr,
    output logic                          icacheDone,
    input  logic                          dcacheReq,
    input  logic                          dcacheWrite,
    input  logic [31-BLOCK_WIDTH:0]       dcacheAddr,
    input  logic [(2**BLOCK_WIDTH)*8-1:0] dcacheWData,
    output logic                          dcacheDone,
    input  logic                          ioReq,
    input  logic                          ioWrite,
    input  logic [31:0]                   ioAddr,
    input  logic [7:0]                    ioWData,
    output logic                          ioDone,
    output logic [7:0]                    ioRData,
    output logic [(2**BLOCK_WIDTH)*8-1:0] blockOut
);
    localparam int                     BLOCK_SIZE = 2 ** BLOCK_WIDTH;
    localparam logic [BLOCK_WIDTH-1:0] LAST_OFF   = BLOCK_WIDTH'(BLOCK_SIZE - 1);

    state_t                   state_q, state_d;
    owner_t                   owner_q, owner_d;
    logic [BLOCK_WIDTH-1:0]   off_q, off_d;
    logic                     tail_q, tail_d;
    logic [31:0]              addr_q, addr_d;
    logic [BLOCK_SIZE*8-1:0]  block_q, block_d;
    logic [7:0]               iordata_q, iordata_d;

    logic [2:0]               w_grant;
    logic [BLOCK_WIDTH-1:0]   w_cap_idx;
    logic                     w_done;

    mem_port_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk_i        (clkIn),
        .rst_i        (resetIn),
        .en_i         (readyIn),
        .arb_en_i     (state_q == ST_IDLE),
        .icache_req_i (icacheReq),
        .dcache_req_i (dcacheReq),
        .io_req_i     (ioReq),
        .grant_o      (w_grant)
    );

    // Read data lags its address by one cycle, so capture trails the offset.
    assign w_cap_idx = tail_q ? LAST_OFF : (off_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        off_d     = off_q;
        tail_d    = tail_q;
        addr_d    = addr_q;
        block_d   = block_q;
        iordata_d = iordata_q;
        case (state_q)
            ST_IDLE: begin
                off_d  = '0;
                tail_d = 1'b0;
                if (w_grant[OWN_IO]) begin
                    owner_d = OWN_IO;
                    addr_d  = ioAddr;
                    state_d = ioWrite ? ST_IO_WR : ST_IO_RD;
                end else if (w_grant[OWN_DCACHE]) begin
                    owner_d = OWN_DCACHE;
                    addr_d  = {dcacheAddr, {BLOCK_WIDTH{1'b0}}};
                    state_d = dcacheWrite ? ST_WR_BLK : ST_RD_BLK;
                end else if (w_grant[OWN_ICACHE]) begin
                    owner_d = OWN_ICACHE;
                    addr_d  = {icacheAddr, {BLOCK_WIDTH{1'b0}}};
                    state_d = ST_RD_BLK;
                end
            end
            ST_RD_BLK: begin
                if ((off_q != '0) || tail_q)
                    block_d[{w_cap_idx, 3'b000} +: 8] = memIn;
                if (tail_q)                state_d = ST_DONE;
                else if (off_q == LAST_OFF) tail_d = 1'b1;
                else                        off_d  = off_q + 1'b1;
            end
            ST_WR_BLK: begin
                if (off_q == LAST_OFF) state_d = ST_DONE;
                else                   off_d   = off_q + 1'b1;
            end
            ST_IO_RD: begin
                if (tail_q) begin
                    iordata_d = memIn;
                    state_d   = ST_DONE;
                end else begin
                    tail_d = 1'b1;
                end
            end
            ST_IO_WR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_ICACHE;
            off_q     <= '0;
            tail_q    <= 1'b0;
            addr_q    <= '0;
            block_q   <= '0;
            iordata_q <= '0;
        end else if (readyIn) begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            off_q     <= off_d;
            tail_q    <= tail_d;
            addr_q    <= addr_d;
            block_q   <= block_d;
            iordata_q <= iordata_d;
        end
    end

    always_comb begin
        memAddr      = '0;
        memOut       = '0;
        readWriteOut = RW_READ;
        case (state_q)
            ST_RD_BLK: memAddr = {addr_q[31:BLOCK_WIDTH], off_q};
            ST_WR_BLK: begin
                memAddr = {addr_q[31:BLOCK_WIDTH], off_q};
                memOut  = dcacheWData[{off_q, 3'b000} +: 8];
            end
            ST_IO_RD:  memAddr = addr_q;
            ST_IO_WR: begin
                memAddr = addr_q;
                memOut  = ioWData;
            end
            default: ;
        endcase
        if (readyIn && ((state_q == ST_WR_BLK) || (state_q == ST_IO_WR)))
            readWriteOut = RW_WRITE;
    end

    // Gated by readyIn so a stalled DONE cycle still yields a single pulse.
    assign w_done     = readyIn && (state_q == ST_DONE);
    assign icacheDone = w_done && (owner_q == OWN_ICACHE);
    assign dcacheDone = w_done && (owner_q == OWN_DCACHE);
    assign ioDone     = w_done && (owner_q == OWN_IO);
    assign ioRData    = iordata_q;
    assign blockOut   = block_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench                  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mem_port_arbiter;
    localparam logic [127:0] c_BLOCK = 128'h0F0E0D0C0B0A09080706050403020100;

    logic         clkIn = 1'b0;
    logic         resetIn, readyIn;
    logic [7:0]   memIn = 8'h00;
    logic [31:0]  memAddr;
    logic [7:0]   memOut;
    logic         readWriteOut;
    logic         icacheReq, dcacheReq, dcacheWrite, ioReq, ioWrite;
    logic [27:0]  icacheAddr, dcacheAddr;
    logic [127:0] dcacheWData, blockOut;
    logic         icacheDone, dcacheDone, ioDone;
    logic [31:0]  ioAddr;
    logic [7:0]   ioWData, ioRData;

    logic         fixed_en;
    logic [7:0]   fixed_val;
    int           errors = 0;
    int           checks = 0;

    mem_port_arbiter dut (
        .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .memIn(memIn),
        .memAddr(memAddr), .memOut(memOut), .readWriteOut(readWriteOut),
        .icacheReq(icacheReq), .icacheAddr(icacheAddr), .icacheDone(icacheDone),
        .dcacheReq(dcacheReq), .dcacheWrite(dcacheWrite), .dcacheAddr(dcacheAddr),
        .dcacheWData(dcacheWData), .dcacheDone(dcacheDone),
        .ioReq(ioReq), .ioWrite(ioWrite), .ioAddr(ioAddr), .ioWData(ioWData),
        .ioDone(ioDone), .ioRData(ioRData), .blockOut(blockOut)
    );

    always #5 clkIn = ~clkIn;

    // RAM model: returns the low address byte one cycle later, frozen with readyIn.
    always @(posedge clkIn) if (readyIn) memIn <= fixed_en ? fixed_val : memAddr[7:0];

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic apply_reset();
        icacheReq = 0; dcacheReq = 0; dcacheWrite = 0; ioReq = 0; ioWrite = 0;
        icacheAddr = '0; dcacheAddr = '0; dcacheWData = '0; ioAddr = '0; ioWData = '0;
        readyIn = 1; fixed_en = 0; fixed_val = 8'h00;
        resetIn = 1;
        tick();
        tick();
        resetIn = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL reset_memAddr got=%h exp=0", memAddr); end
        checks++; if (memOut !== 8'h0) begin errors++; $display("FAIL reset_memOut got=%h exp=0", memOut); end
        checks++; if (readWriteOut !== 1'b1) begin errors++; $display("FAIL reset_rw got=%b exp=1", readWriteOut); end
        checks++; if (blockOut !== 128'h0) begin errors++; $display("FAIL reset_blockOut got=%h exp=0", blockOut); end
        checks++; if (ioRData !== 8'h0) begin errors++; $display("FAIL reset_ioRData got=%h exp=0", ioRData); end
        checks++; if ({ioDone, dcacheDone, icacheDone} !== 3'b000) begin errors++;
            $display("FAIL reset_done got=%b exp=000", {ioDone, dcacheDone, icacheDone}); end
        checks++; if (dut.u_arb.starve_q !== 3'd0) begin errors++; $display("FAIL reset_starve got=%0d exp=0", dut.u_arb.starve_q); end
    endtask

    task automatic test_icache_refill();
        apply_reset();
        icacheReq = 1; icacheAddr = 28'h0000010;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (memAddr !== 32'h100 + 32'(k) || readWriteOut !== 1'b1) begin errors++;
                $display("FAIL icache_addr k=%0d got=%h/%b exp=%h/1", k, memAddr, readWriteOut, 32'h100 + 32'(k)); end
        end
        tick();
        checks++; if (icacheDone !== 1'b0) begin errors++; $display("FAIL icache_early_done got=%b exp=0", icacheDone); end
        tick();
        checks++; if (icacheDone !== 1'b1 || dcacheDone !== 1'b0 || ioDone !== 1'b0) begin errors++;
            $display("FAIL icache_done got=%b%b%b exp=001", ioDone, dcacheDone, icacheDone); end
        checks++; if (blockOut !== c_BLOCK) begin errors++; $display("FAIL icache_block got=%h exp=%h", blockOut, c_BLOCK); end
        icacheReq = 0;
        tick();
        checks++; if (icacheDone !== 1'b0 || blockOut !== c_BLOCK) begin errors++;
            $display("FAIL icache_after_done got=%b %h exp=0 %h", icacheDone, blockOut, c_BLOCK); end
    endtask

    task automatic test_dcache_writeback();
        apply_reset();
        for (int k = 0; k < 16; k++) dcacheWData[8*k +: 8] = 8'hA0 + 8'(k);
        dcacheReq = 1; dcacheWrite = 1; dcacheAddr = 28'h0000020;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (readWriteOut !== 1'b0 || memAddr !== 32'h200 + 32'(k) || memOut !== 8'hA0 + 8'(k)) begin errors++;
                $display("FAIL dcache_wr k=%0d got=%b/%h/%h exp=0/%h/%h", k, readWriteOut, memAddr, memOut,
                         32'h200 + 32'(k), 8'hA0 + 8'(k)); end
        end
        tick();
        checks++; if ({ioDone, dcacheDone, icacheDone} !== 3'b010 || readWriteOut !== 1'b1) begin errors++;
            $display("FAIL dcache_done got=%b%b%b rw=%b exp=010 rw=1", ioDone, dcacheDone, icacheDone, readWriteOut); end
        dcacheReq = 0;
        tick();
        checks++; if (dcacheDone !== 1'b0) begin errors++; $display("FAIL dcache_single_pulse got=%b exp=0", dcacheDone); end
    endtask

    task automatic test_all_three();
        logic [2:0] exp_done;
        apply_reset();
        ioReq = 1; ioWrite = 0; ioAddr = 32'h0000_1234;
        dcacheReq = 1; dcacheWrite = 0; dcacheAddr = 28'h0000040;
        icacheReq = 1; icacheAddr = 28'h0000050;
        for (int c = 1; c <= 45; c++) begin
            tick();
            exp_done = {c == 3, c == 22, c == 41};
            checks++; if ({ioDone, dcacheDone, icacheDone} !== exp_done) begin errors++;
                $display("FAIL order_done cyc=%0d got=%b exp=%b", c, {ioDone, dcacheDone, icacheDone}, exp_done); end
            if (c == 1) begin checks++; if (memAddr !== 32'h1234) begin errors++; $display("FAIL order_io_addr got=%h exp=1234", memAddr); end end
            if (c == 5) begin checks++; if (memAddr !== 32'h400) begin errors++; $display("FAIL order_dc_addr got=%h exp=400", memAddr); end end
            if (c == 24) begin checks++; if (memAddr !== 32'h500) begin errors++; $display("FAIL order_ic_addr got=%h exp=500", memAddr); end end
            if (c == 4 || c == 23) begin checks++; if (memAddr !== 32'h0 || readWriteOut !== 1'b1) begin errors++;
                $display("FAIL order_idle cyc=%0d got=%h/%b exp=0/1", c, memAddr, readWriteOut); end end
            if (ioDone) ioReq = 0;
            if (dcacheDone) dcacheReq = 0;
            if (icacheDone) icacheReq = 0;
        end
    endtask

    task automatic test_starvation();
        int dc_cnt;
        apply_reset();
        dc_cnt = 0;
        dcacheReq = 1; dcacheWrite = 1; dcacheAddr = 28'h0000060; dcacheWData = {8{16'h55AA}};
        icacheReq = 1; icacheAddr = 28'h0000070;
        for (int c = 1; c <= 91; c++) begin
            tick();
            if (dcacheDone) dc_cnt++;
            if (c == 55) begin checks++; if (dut.u_arb.starve_q !== 3'd4) begin errors++;
                $display("FAIL starve_sat got=%0d exp=4", dut.u_arb.starve_q); end end
            if (c == 73) begin
                checks++; if (memAddr !== 32'h700 || readWriteOut !== 1'b1) begin errors++;
                    $display("FAIL starve_ic_grant got=%h/%b exp=700/1", memAddr, readWriteOut); end
                checks++; if (dut.u_arb.starve_q !== 3'd0) begin errors++;
                    $display("FAIL starve_clear got=%0d exp=0", dut.u_arb.starve_q); end
            end
            if (c < 90) begin checks++; if (icacheDone !== 1'b0) begin errors++; $display("FAIL starve_ic_early cyc=%0d", c); end end
            if (c == 90) begin
                checks++; if (icacheDone !== 1'b1 || dc_cnt != 4) begin errors++;
                    $display("FAIL starve_ic_done got=%b dc=%0d exp=1 dc=4", icacheDone, dc_cnt); end
                icacheReq = 0; dcacheReq = 0;
            end
        end
    endtask

    task automatic test_io();
        apply_reset();
        fixed_en = 1; fixed_val = 8'h5A;
        ioReq = 1; ioWrite = 0; ioAddr = 32'h0003_0000;
        tick();
        checks++; if (memAddr !== 32'h30000 || readWriteOut !== 1'b1 || ioDone !== 1'b0) begin errors++;
            $display("FAIL io_rd_addr got=%h/%b/%b exp=30000/1/0", memAddr, readWriteOut, ioDone); end
        tick();
        checks++; if (ioDone !== 1'b0) begin errors++; $display("FAIL io_rd_early got=%b exp=0", ioDone); end
        tick();
        checks++; if (ioDone !== 1'b1 || ioRData !== 8'h5A) begin errors++;
            $display("FAIL io_rd_done got=%b/%h exp=1/5a", ioDone, ioRData); end
        ioReq = 0; fixed_en = 0;
        tick();
        ioReq = 1; ioWrite = 1; ioAddr = 32'h0000_0040; ioWData = 8'hC3;
        tick();
        checks++; if (readWriteOut !== 1'b0 || memAddr !== 32'h40 || memOut !== 8'hC3) begin errors++;
            $display("FAIL io_wr got=%b/%h/%h exp=0/40/c3", readWriteOut, memAddr, memOut); end
        readyIn = 0; #1;
        checks++; if (readWriteOut !== 1'b1) begin errors++; $display("FAIL io_wr_stall_rw got=%b exp=1", readWriteOut); end
        tick();
        readyIn = 1; #1;
        checks++; if (readWriteOut !== 1'b0 || memAddr !== 32'h40 || ioDone !== 1'b0) begin errors++;
            $display("FAIL io_wr_resume got=%b/%h/%b exp=0/40/0", readWriteOut, memAddr, ioDone); end
        tick();
        checks++; if (ioDone !== 1'b1 || ioRData !== 8'h5A) begin errors++;
            $display("FAIL io_wr_done got=%b/%h exp=1/5a", ioDone, ioRData); end
        ioReq = 0;
    endtask

    task automatic test_stall_and_reset();
        int stray;
        apply_reset();
        icacheReq = 1; icacheAddr = 28'h0000010;
        for (int k = 0; k < 8; k++) tick();
        readyIn = 0; #1;
        for (int s = 0; s < 3; s++) begin
            checks++; if (memAddr !== 32'h107 || readWriteOut !== 1'b1 || icacheDone !== 1'b0) begin errors++;
                $display("FAIL stall_hold s=%0d got=%h/%b exp=107/1", s, memAddr, readWriteOut); end
            tick();
        end
        readyIn = 1;
        for (int c = 12; c <= 21; c++) begin
            tick();
            if (c == 12) begin checks++; if (memAddr !== 32'h108) begin errors++; $display("FAIL stall_resume got=%h exp=108", memAddr); end end
            checks++; if (icacheDone !== (c == 21)) begin errors++; $display("FAIL stall_done cyc=%0d got=%b", c, icacheDone); end
        end
        checks++; if (blockOut !== c_BLOCK) begin errors++; $display("FAIL stall_block got=%h exp=%h", blockOut, c_BLOCK); end
        for (int c = 22; c <= 32; c++) tick();
        checks++; if (memAddr !== 32'h109) begin errors++; $display("FAIL rst_offset9 got=%h exp=109", memAddr); end
        resetIn = 1; icacheReq = 0;
        tick();
        checks++; if (blockOut !== 128'h0 || memAddr !== 32'h0 || readWriteOut !== 1'b1 || icacheDone !== 1'b0) begin errors++;
            $display("FAIL rst_abort got=%h/%h/%b/%b exp=0/0/1/0", blockOut, memAddr, readWriteOut, icacheDone); end
        resetIn = 0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (icacheDone || dcacheDone || ioDone || memAddr != 32'h0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", stray); end
    endtask

    initial begin
        test_reset();
        test_icache_refill();
        test_dcache_writeback();
        test_all_three();
        test_starvation();
        test_io();
        test_stall_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
